// File: rtl/icache_line_fill_if.sv
// Fetch/line-fill bundle between the IF stage, the instruction cache and the
// memory controller's line-fetch port.
interface icache_line_fill_if;
   logic         rdy;
   logic         flush;
   logic         fetch_valid;
   logic [31:0]  fetch_pc;
   logic         inst_valid;
   logic [31:0]  inst;
   logic         ifetch_en;
   logic [31:0]  ifetch_pc;
   logic         ifetch_done;
   logic [511:0] ifetch_data;

   modport slave (
      input  rdy, flush, fetch_valid, fetch_pc, ifetch_done, ifetch_data,
      output inst_valid, inst, ifetch_en, ifetch_pc
   );

   modport master (
      output rdy, flush, fetch_valid, fetch_pc, ifetch_done, ifetch_data,
      input  inst_valid, inst, ifetch_en, ifetch_pc
   );
endinterface

// File: rtl/icache_line_fill.sv
// Direct-mapped instruction cache: combinational hit path, one outstanding
// 64-byte line fill on a miss.
module icache_line_fill #(
   parameter int INDEX_BITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   icache_line_fill_if.slave  bus
);
   localparam int TAG_BITS = 26 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                state_reg, state_next;
   logic [511:0]          data_mem [LINES];
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [LINES-1:0]      valid_reg;
   logic [INDEX_BITS-1:0] miss_index_reg, miss_index_next;
   logic [TAG_BITS-1:0]   miss_tag_reg, miss_tag_next;
   logic                  drop_reg, drop_next;
   logic                  ifetch_en_reg, ifetch_en_next;
   logic [31:0]           ifetch_pc_reg, ifetch_pc_next;
   logic                  fill_we;

   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic [3:0]            word;
   logic [511:0]          line;
   logic                  hit;
   logic                  unused_pc_bits;

   assign index          = bus.fetch_pc[6 +: INDEX_BITS];
   assign tag            = bus.fetch_pc[31 -: TAG_BITS];
   assign word           = bus.fetch_pc[5:2];
   assign unused_pc_bits = ^bus.fetch_pc[1:0];

   assign line = data_mem[index];
   assign hit  = valid_reg[index] && (tag_mem[index] == tag);

   assign bus.inst_valid = !rst && bus.rdy && (state_reg == IDLE) && bus.fetch_valid && hit;
   assign bus.inst       = bus.inst_valid ? line[{word, 5'b0} +: 32] : 32'h0;
   assign bus.ifetch_en  = ifetch_en_reg;
   assign bus.ifetch_pc  = ifetch_pc_reg;

   always_comb begin
      state_next      = state_reg;
      miss_index_next = miss_index_reg;
      miss_tag_next   = miss_tag_reg;
      drop_next       = drop_reg;
      ifetch_en_next  = ifetch_en_reg;
      ifetch_pc_next  = ifetch_pc_reg;
      fill_we         = 1'b0;
      case (state_reg)
         IDLE: begin
            // A flush cycle never issues a request; the lookup retries next cycle.
            if (bus.fetch_valid && !hit && !bus.flush) begin
               state_next      = MISS;
               ifetch_en_next  = 1'b1;
               ifetch_pc_next  = {bus.fetch_pc[31:6], 6'b0};
               miss_index_next = index;
               miss_tag_next   = tag;
               drop_next       = 1'b0;
            end
         end
         MISS: begin
            if (bus.ifetch_done) begin
               fill_we        = 1'b1;
               state_next     = IDLE;
               ifetch_en_next = 1'b0;
               drop_next      = 1'b0;
            end else if (bus.flush) begin
               drop_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         valid_reg      <= '0;
         drop_reg       <= 1'b0;
         ifetch_en_reg  <= 1'b0;
         ifetch_pc_reg  <= 32'h0;
         miss_index_reg <= '0;
         miss_tag_reg   <= '0;
      end else if (bus.rdy) begin
         state_reg      <= state_next;
         drop_reg       <= drop_next;
         ifetch_en_reg  <= ifetch_en_next;
         ifetch_pc_reg  <= ifetch_pc_next;
         miss_index_reg <= miss_index_next;
         miss_tag_reg   <= miss_tag_next;
         // Flush wins over a coincident fill, so that line also ends up invalid.
         if (bus.flush)
            valid_reg <= '0;
         else if (fill_we)
            valid_reg[miss_index_reg] <= !drop_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && bus.rdy && fill_we) begin
         data_mem[miss_index_reg] <= bus.ifetch_data;
         tag_mem[miss_index_reg]  <= miss_tag_reg;
      end
   end
endmodule
